// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: select codes, FSM states and opcode helpers.
// Pure declarations; no timing or flow-control behaviour lives here.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_MULT  = 4'd3;
    localparam logic [3:0] ALU_MULTU = 4'd4;
    localparam logic [3:0] ALU_DIV   = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_XOR   = 4'd9;
    localparam logic [3:0] ALU_NOR   = 4'd10;
    localparam logic [3:0] ALU_SLL   = 4'd11;
    localparam logic [3:0] ALU_SRL   = 4'd12;
    localparam logic [3:0] ALU_SRA   = 4'd13;
    localparam logic [3:0] ALU_DIVU  = 4'd14;
    localparam logic [3:0] ALU_NONE  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] sel);
        return (sel == ALU_MULT) || (sel == ALU_MULTU) || (sel == ALU_DIV) || (sel == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] sel);
        return (sel == ALU_MULT) || (sel == ALU_DIV);
    endfunction

    function automatic logic is_div(input logic [3:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the EX stage and the sequenced ALU.
// start is only honoured while busy is low; done pulses once per accepted op.
interface alu_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [3:0]         select;
    logic [WIDTH-1:0]   reg1;
    logic [WIDTH-1:0]   reg2;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;
    logic               zero_flag;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output start, select, reg1, reg2, shamt,
        input  busy, done, out, zero_flag, hi, lo
    );

    modport slave (
        input  start, select, reg1, reg2, shamt,
        output busy, done, out, zero_flag, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned shift-add multiplier / restoring divider on one 2*WIDTH accumulator, one bit per en cycle.
// WIDTH en cycles after load the raw HI:LO is valid; no backpressure, the caller paces en.
module muldiv_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               mode_q, mode_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Multiplier: add B into the upper half when the multiplier LSB is set, then shift right with carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divider: remainder shifts in the next dividend bit; the quotient bit fills the vacated LSB.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, b_q};
        rem_new  = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            b_d    = b_mag;
            cnt_d  = '0;
            mode_d = mode;
        end else if (en) begin
            acc_d = mode_q ? div_next : mul_next;
            cnt_d = cnt_q + SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign last   = (cnt_q == CNT_LAST);
    assign res_hi = acc_q[2*WIDTH-1:WIDTH];
    assign res_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops give done one cycle after start; mul/div take WIDTH+1 edges.
// While busy, start is ignored (not queued); a start in the done cycle is accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             b_zero_q, b_zero_d;

    logic [WIDTH-1:0]   sc_res;
    logic               sgn_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               mdu_load, mdu_en, mdu_last;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        sc_res = '0;
        case (bus.select)
            ALU_AND:  sc_res = bus.reg1 & bus.reg2;
            ALU_OR:   sc_res = bus.reg1 | bus.reg2;
            ALU_ADD:  sc_res = bus.reg1 + bus.reg2;
            ALU_SUB:  sc_res = bus.reg1 - bus.reg2;
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.reg1) < $signed(bus.reg2)};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.reg1 < bus.reg2};
            ALU_XOR:  sc_res = bus.reg1 ^ bus.reg2;
            ALU_NOR:  sc_res = ~(bus.reg1 | bus.reg2);
            ALU_SLL:  sc_res = bus.reg1 << bus.shamt;
            ALU_SRL:  sc_res = bus.reg1 >> bus.shamt;
            ALU_SRA:  sc_res = $signed(bus.reg1) >>> bus.shamt;
            default:  sc_res = '0;
        endcase
    end

    // The iterative core is unsigned; signed ops feed it magnitudes and FIX restores signs.
    always_comb begin
        sgn_in = is_signed_op(bus.select);
        a_mag  = (sgn_in && bus.reg1[WIDTH-1]) ? -bus.reg1 : bus.reg1;
        b_mag  = (sgn_in && bus.reg2[WIDTH-1]) ? -bus.reg2 : bus.reg2;
    end

    muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (mdu_load),
        .en     (mdu_en),
        .mode   (is_div(bus.select)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (mdu_last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    always_comb begin
        prod = {res_hi, res_lo};
        if (a_neg_q ^ b_neg_q) begin
            prod = -prod;
        end
        quo = (a_neg_q ^ b_neg_q) ? -res_lo : res_lo;
        rem = a_neg_q ? -res_hi : res_hi;
        if (is_div(op_q)) begin
            fix_lo = b_zero_q ? '1  : quo;
            fix_hi = b_zero_q ? a_q : rem;
        end else begin
            fix_lo = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        out_d    = out_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        a_d      = a_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        mdu_load = 1'b0;
        mdu_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_multicycle(bus.select)) begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        mdu_load = 1'b1;
                        op_d     = bus.select;
                        a_d      = bus.reg1;
                        a_neg_d  = sgn_in && bus.reg1[WIDTH-1];
                        b_neg_d  = sgn_in && bus.reg2[WIDTH-1];
                        b_zero_d = (bus.reg2 == '0);
                    end else begin
                        out_d  = sc_res;
                        zero_d = (sc_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                mdu_en = 1'b1;
                if (mdu_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                out_d   = fix_lo;
                zero_d  = (fix_lo == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            out_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= ALU_AND;
            a_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            a_q      <= a_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out       = out_q;
    assign bus.zero_flag = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expected values.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    alu_seq_if #(.WIDTH(W)) bif();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh);
        bif.start  = 1'b1;
        bif.select = sel;
        bif.reg1   = a;
        bif.reg2   = b;
        bif.shamt  = sh;
    endtask

    task automatic run_single(input string tag, input logic [3:0] sel, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [4:0] sh,
                              input logic [W-1:0] exp_out, input logic exp_z);
        drive(sel, a, b, sh);
        step();
        bif.start = 1'b0;
        chk({tag, ".done"}, bif.done, 1);
        chk({tag, ".busy"}, bif.busy, 0);
        chk({tag, ".out"}, bif.out, exp_out);
        chk({tag, ".zero"}, bif.zero_flag, exp_z);
    endtask

    task automatic run_multi(input string tag, input logic [3:0] sel, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo);
        int n;
        drive(sel, a, b, 5'd0);
        step();
        bif.start  = 1'b0;
        bif.select = ALU_ADD;
        bif.reg1   = 32'hDEADBEEF;
        bif.reg2   = 32'h0;
        chk({tag, ".busy"}, bif.busy, 1);
        n = 0;
        while (!bif.done && n < 100) begin
            step();
            n++;
        end
        chk({tag, ".lat"}, n, W + 1);
        chk({tag, ".hi"}, bif.hi, exp_hi);
        chk({tag, ".lo"}, bif.lo, exp_lo);
        chk({tag, ".out"}, bif.out, exp_lo);
        chk({tag, ".zero"}, bif.zero_flag, exp_lo == 32'h0);
        chk({tag, ".busy_end"}, bif.busy, 0);
    endtask

    logic [3:0]   sc_sel [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU,
                                  ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NONE};
    logic [W-1:0] sc_exp [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                  32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000,
                                  32'hFFFFFFF8, 32'h3FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    logic         sc_z   [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ndone;
        logic [W-1:0] cap_hi, cap_lo, cap_out;

        reset      = 1'b1;
        bif.start  = 1'b0;
        bif.select = ALU_AND;
        bif.reg1   = '0;
        bif.reg2   = '0;
        bif.shamt  = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst.busy", bif.busy, 0);
        chk("rst.done", bif.done, 0);
        chk("rst.out", bif.out, 0);
        chk("rst.zero", bif.zero_flag, 0);
        chk("rst.hi", bif.hi, 0);
        chk("rst.lo", bif.lo, 0);

        for (int i = 0; i < 12; i++) begin
            run_single($sformatf("sc%0d", sc_sel[i]), sc_sel[i], 32'hFFFFFFFE, 32'hFFFFFFFF,
                       5'd2, sc_exp[i], sc_z[i]);
        end

        run_multi("mult", ALU_MULT, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000002);
        run_multi("multu", ALU_MULTU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000002);
        run_multi("div", ALU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_multi("divu0", ALU_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_multi("divmin", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_multi("divs0", ALU_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // add request arriving mid-multiply must be dropped
        drive(ALU_MULTU, 32'h00010000, 32'h00030003, 5'd0);
        step();
        bif.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        drive(ALU_ADD, 32'h1, 32'h2, 5'd0);
        step();
        bif.start = 1'b0;
        ndone   = 0;
        cap_hi  = '0;
        cap_lo  = '0;
        cap_out = '0;
        for (int i = 0; i < 40; i++) begin
            if (bif.done) begin
                ndone++;
                cap_hi  = bif.hi;
                cap_lo  = bif.lo;
                cap_out = bif.out;
            end
            step();
        end
        chk("ign.ndone", ndone, 1);
        chk("ign.hi", cap_hi, 32'h00000003);
        chk("ign.lo", cap_lo, 32'h00030000);
        chk("ign.out", cap_out, 32'h00030000);

        // reset mid-divide aborts the op
        drive(ALU_DIV, 32'd100, 32'd7, 5'd0);
        step();
        bif.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort.busy", bif.busy, 0);
        chk("abort.done", bif.done, 0);
        chk("abort.out", bif.out, 0);
        chk("abort.zero", bif.zero_flag, 0);
        chk("abort.hi", bif.hi, 0);
        chk("abort.lo", bif.lo, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bif.done) ndone++;
            step();
        end
        chk("abort.ndone", ndone, 0);
        run_single("add34", ALU_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);

        // reset wins over a simultaneous start
        drive(ALU_ADD, 32'd5, 32'd5, 5'd0);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bif.start = 1'b0;
        chk("rstpri.done", bif.done, 0);
        chk("rstpri.out", bif.out, 0);

        // back-to-back single-cycle ops with HI/LO preserved
        run_multi("div2", ALU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        drive(ALU_ADD, 32'd5, 32'd6, 5'd0);
        step();
        chk("b2b.add.done", bif.done, 1);
        chk("b2b.add.out", bif.out, 32'd11);
        drive(ALU_SUB, 32'd5, 32'd6, 5'd0);
        step();
        chk("b2b.sub.done", bif.done, 1);
        chk("b2b.sub.out", bif.out, 32'hFFFFFFFF);
        drive(ALU_SLT, 32'd5, 32'd6, 5'd0);
        step();
        bif.start = 1'b0;
        chk("b2b.slt.done", bif.done, 1);
        chk("b2b.slt.out", bif.out, 32'd1);
        step();
        chk("b2b.idle.done", bif.done, 0);
        chk("b2b.hi", bif.hi, 32'hFFFFFFFF);
        chk("b2b.lo", bif.lo, 32'hFFFFFFFD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the processor's combinational ALU. Keeps the existing 4-bit select encoding and zero flag for logic, compare and shift operations, adds arithmetic shift right, and adds iterative signed/unsigned multiply and divide writing HI/LO. Sits in the EX stage behind a start/busy/done handshake so the pipeline can stall on multi-cycle operations.

## Interface
- `WIDTH`, 32, datapath width in bits (≥ 8, power of two).
- `SHAMT_W`, $clog2(WIDTH), shift-amount width.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: operation request; sampled only when `busy`=0.
- `select` in 4: operation code.
- `reg1`, `reg2` in WIDTH: operands A and B.
- `shamt` in SHAMT_W: shift amount for shift ops.
- `busy` out 1: multi-cycle operation in flight.
- `done` out 1: one-cycle pulse; `out`/`zero_flag` valid in this cycle.
- `out` out WIDTH: result; holds until the next `done`.
- `zero_flag` out 1: `out` == 0; updated with `out`.
- `hi`, `lo` out WIDTH: multiply/divide result registers.

## Operation
- Single-cycle codes: 0 and, 1 or, 2 add, 6 sub (A−B), 7 slt (signed A<B → 1 else 0), 8 sltu (unsigned), 9 xor, 10 nor, 11 sll A by shamt, 12 srl A by shamt, 13 sra A by shamt (sign-filling).
- Add/sub wrap modulo 2^WIDTH; no overflow trap or flag.
- Multi-cycle codes: 3 mult (signed), 4 multu, 5 div (signed), 14 divu.
- Multiply: HI:LO = full 2·WIDTH-bit product.
- Divide: LO = quotient, HI = remainder.
- Signed divide: quotient truncates toward zero. Remainder takes the sign of the dividend.
- Signed divide of MIN by −1: LO = MIN, HI = 0.
- Divide by zero: LO = all ones, HI = A. No exception is raised.
- For multi-cycle codes, `out` = new LO.
- Code 15 is unused: `out` = 0, `zero_flag` = 1, single-cycle done.
- FSM states: IDLE, RUN, FIX.
  - IDLE → RUN on `start` with a multi-cycle code.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE unconditionally.
- Signed ops iterate on operand magnitudes. FIX applies the sign corrections and writes `hi`, `lo`, `out` and `zero_flag`.

## Timing
- Reset values: `busy`=0, `done`=0, `out`=0, `zero_flag`=0, `hi`=0, `lo`=0, state IDLE, iteration counter 0.
- Single-cycle op, start sampled at edge e0:
  - `out` and `zero_flag` are registered at e0.
  - `done`=1 in the cycle after e0; `busy` stays 0.
- Multi-cycle op, start sampled at e0:
  - `busy`=1 from the cycle after e0 until the cycle after e(WIDTH+1).
  - Iterations occur at edges e1..eWIDTH; FIX executes at e(WIDTH+1).
  - `done`=1 and `busy`=0 in the cycle after e(WIDTH+1), i.e. latency WIDTH+1 edges.
- Operands and select are latched at e0. Later input changes have no effect on the operation in flight.
- `start` while `busy`=1 is ignored (not queued).
- `start` in the same cycle `done`=1 is accepted; back-to-back throughput is 1 op per cycle for single-cycle codes.
- `hi`/`lo` change only at FIX and on reset. Single-cycle ops leave them untouched.
- `reset` asserted during RUN or FIX:
  - The op is aborted; there is no `done` for it.
  - All outputs return to their reset values at that edge.
- `reset` has priority over `start` in the same cycle.

## Structure
- Package `alu_pkg`:
  - localparams for all 16 select codes (ALU_AND … ALU_DIVU);
  - FSM state enum (IDLE/RUN/FIX);
  - helper `is_multicycle(select)`.
- Sub-module `muldiv_iter`:
  - shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator and counter;
  - inputs: unsigned magnitudes, a load strobe and a mode bit;
  - output: raw HI:LO.
- Top level holds the single-cycle datapath, the FSM, sign handling and output registers.

## Test plan
- WIDTH=32, A=−2, B=−1, shamt=2, each single-cycle code in turn. Required `out`, each with `done` exactly one cycle after start:
  - add 0xFFFFFFFD; sub 0xFFFFFFFF; and 0xFFFFFFFE; or 0xFFFFFFFF;
  - slt 1; sltu 1; xor 0x00000001; nor 0x00000000 with `zero_flag`=1;
  - sll 0xFFFFFFF8; srl 0x3FFFFFFF; sra 0xFFFFFFFF.
- mult A=−2, B=−1 → HI=0, LO=2 with `done` 33 edges after start. multu with the same operands → HI=0xFFFFFFFD, LO=0x00000002.
- div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → LO=0xFFFFFFFF, HI=7. div A=0x80000000, B=−1 → LO=0x80000000, HI=0.
- Start multu, pulse `start` with add at iteration 10 → add ignored; only one `done`; HI/LO correct.
- Start div, assert `reset` at iteration 5 → next cycle all outputs 0, `busy`=0, no `done`. A following add 3+4 → `out`=7 after one cycle.
- Back-to-back: add, sub, slt on consecutive cycles → three consecutive `done` pulses with results in order; HI/LO unchanged from prior values.
